fetch_stage: RTL

//   IF stage of the 32-bit MIPS pipeline: owns the PC, drives the word address of the

---
 rtl/fetch_stage_if.sv | 44 ++++
 rtl/fetch_stage.sv | 139 +++++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage_if
//  Brief    : IF-stage bus bundle: hazard/EX controls, imem port, IF/ID outputs.
//             Perf counter signals exist only when FETCH_PERF_CNT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
interface fetch_stage_if;
  logic        stall_i;
  logic        flush_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic [31:0] ifid_instr_o;
  logic [31:0] ifid_pc_plus4_o;
  logic        ifid_valid_o;
  logic        halted_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt_o;
  logic [31:0] perf_stall_cnt_o;

  modport master (
    input  stall_i, flush_i, redirect_i, redirect_pc_i, imem_instr_i,
    output imem_addr_o, ifid_instr_o, ifid_pc_plus4_o, ifid_valid_o, halted_o,
    output perf_fetch_cnt_o, perf_stall_cnt_o
  );
  modport slave (
    output stall_i, flush_i, redirect_i, redirect_pc_i, imem_instr_i,
    input  imem_addr_o, ifid_instr_o, ifid_pc_plus4_o, ifid_valid_o, halted_o,
    input  perf_fetch_cnt_o, perf_stall_cnt_o
  );
`else
  modport master (
    input  stall_i, flush_i, redirect_i, redirect_pc_i, imem_instr_i,
    output imem_addr_o, ifid_instr_o, ifid_pc_plus4_o, ifid_valid_o, halted_o
  );
  modport slave (
    output stall_i, flush_i, redirect_i, redirect_pc_i, imem_instr_i,
    input  imem_addr_o, ifid_instr_o, ifid_pc_plus4_o, ifid_valid_o, halted_o
  );
`endif
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Brief    : MIPS IF stage - PC, imem word address, IF/ID register, halt.
//             Optional macro FETCH_PERF_CNT_EN adds fetch/stall counters.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  wire           clk,
  input  wire           rst,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_ifid_instr, w_instr_nxt;
  logic [31:0] r_ifid_pc4, w_pc4_nxt;
  logic        r_ifid_valid, w_valid_nxt;
  logic        w_bubble, w_capture;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_redirect_pc;
  logic        w_unused;

  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_redirect_pc = {bus.redirect_pc_i[31:2], 2'b00};
  assign w_unused      = &{1'b0, bus.redirect_pc_i[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_BOOT;
      r_pc         <= RESET_PC;
      r_ifid_instr <= NOP_WORD;
      r_ifid_pc4   <= 32'd0;
      r_ifid_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_ifid_instr <= w_instr_nxt;
      r_ifid_pc4   <= w_pc4_nxt;
      r_ifid_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_bubble    = 1'b0;
    w_capture   = 1'b0;
    unique case (r_state)
      S_BOOT: begin
        w_state_nxt = S_RUN;
        w_bubble    = 1'b1;
      end
      S_RUN: begin
        if (bus.redirect_i) begin
          w_pc_nxt = w_redirect_pc;
          w_bubble = 1'b1;
        end else if (bus.stall_i) begin
          // stall+flush squashes IF/ID but still holds the PC
          w_bubble = bus.flush_i;
        end else if (bus.flush_i) begin
          w_bubble = 1'b1;
          w_pc_nxt = w_pc_plus4;
        end else if (bus.imem_instr_i == HALT_WORD) begin
          w_bubble    = 1'b1;
          w_state_nxt = S_HALTED;
        end else begin
          w_capture = 1'b1;
          w_pc_nxt  = w_pc_plus4;
        end
      end
      S_HALTED: begin
        w_bubble = 1'b1;
        if (bus.redirect_i) begin
          w_pc_nxt    = w_redirect_pc;
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_BOOT;
        w_bubble    = 1'b1;
      end
    endcase

    w_instr_nxt = r_ifid_instr;
    w_pc4_nxt   = r_ifid_pc4;
    w_valid_nxt = r_ifid_valid;
    if (w_bubble) begin
      w_instr_nxt = NOP_WORD;
      w_pc4_nxt   = 32'd0;
      w_valid_nxt = 1'b0;
    end else if (w_capture) begin
      w_instr_nxt = bus.imem_instr_i;
      w_pc4_nxt   = w_pc_plus4;
      w_valid_nxt = 1'b1;
    end
  end

  assign bus.imem_addr_o     = {2'b00, r_pc[31:2]};
  assign bus.ifid_instr_o    = r_ifid_instr;
  assign bus.ifid_pc_plus4_o = r_ifid_pc4;
  assign bus.ifid_valid_o    = r_ifid_valid;
  assign bus.halted_o        = (r_state == S_HALTED);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt, r_stall_cnt;
  logic        w_stall_evt;

  assign w_stall_evt = (r_state == S_RUN) && bus.stall_i && !bus.redirect_i;

  // saturating event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (w_capture && (r_fetch_cnt != 32'hFFFF_FFFF))
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_stall_evt && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign bus.perf_fetch_cnt_o = r_fetch_cnt;
  assign bus.perf_stall_cnt_o = r_stall_cnt;
`endif

endmodule
`default_nettype wire
